// File: rtl/demux_1_4_reg.sv
// -----------------------------------------------------------------------------
// demux_1_4_reg
// Registered 1-to-4 stream distributor. Each accepted input word goes to the
// output lane chosen by in_sel. Every lane has a one-entry holding register
// with a valid/ready handshake, so lanes never block each other.
//
// Optional feature macro: DEMUX_CNT_EN
//   defined   -> adds lane_cnt, one CNT_W-bit wrapping transfer counter per lane
//   undefined -> lane_cnt port and counters are absent
// -----------------------------------------------------------------------------
module demux_1_4_reg #(
    parameter int WIDTH = 48,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [4*CNT_W-1:0]   lane_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t        r_state     [4];
    lane_state_t        w_state_nxt [4];
    logic [WIDTH-1:0]   r_data      [4];
    logic               w_accept;
    logic [3:0]         w_acc_lane;
    logic [3:0]         w_drain;

    // in_ready looks only at the selected lane; rst_n gates it so nothing is
    // accepted while the block is held in reset.
    assign in_ready = rst_n & ~flush & (~out_valid[in_sel] | out_ready[in_sel]);
    assign w_accept = in_valid & in_ready;

    // Decode the accept onto a single lane and flag output handshakes.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a missed path infers a latch.
        w_acc_lane = 4'b0000;
        w_drain    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_acc_lane[i] = w_accept & (in_sel == 2'(i));
            w_drain[i]    = out_valid[i] & out_ready[i];
        end
    end

    // Per-lane EMPTY/FULL next-state logic; flush empties every lane.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_state_nxt[i] = r_state[i];
            if (flush) begin
                w_state_nxt[i] = EMPTY;
            end else begin
                case (r_state[i])
                    EMPTY:   if (w_acc_lane[i]) w_state_nxt[i] = FULL;
                    FULL:    if (w_drain[i] && !w_acc_lane[i]) w_state_nxt[i] = EMPTY;
                    default: w_state_nxt[i] = EMPTY;
                endcase
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_state[i] <= EMPTY;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            for (int i = 0; i < 4; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    // Lane holding registers: load on accept only, keep contents through
    // drain and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset too, because the lanes must
            // read as zero while reset is asserted; this is a small register
            // file, not a RAM, so resetting it costs nothing structural.
            for (int i = 0; i < 4; i++) r_data[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_lane[i]) r_data[i] <= in_data;
            end
        end
    end

    // Flatten lane state and data onto the output buses.
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_lane
            assign out_valid[g]                  = (r_state[g] == FULL);
            assign out_data[g*WIDTH +: WIDTH]    = r_data[g];
        end
    endgenerate

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt [4];

    // Per-lane output handshake counters; wrap naturally, cleared by reset only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_drain[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
        end
    end

    generate
        for (g = 0; g < 4; g++) begin : g_cnt
            assign lane_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_demux_1_4_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_1_4_reg
// Directed bench for demux_1_4_reg. Inputs change 1 ns after a rising edge;
// outputs are checked 1 ns after the edge (registered) or after the inputs
// settle (combinational in_ready). Build with +define+DEMUX_CNT_EN to also
// exercise the lane counters (instantiated with CNT_W = 4).
// -----------------------------------------------------------------------------
module tb_demux_1_4_reg;

    localparam int WIDTH = 48;
    localparam int CNT_W = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_sel;
    logic [WIDTH-1:0]     in_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [4*WIDTH-1:0]   out_data;
`ifdef DEMUX_CNT_EN
    logic [4*CNT_W-1:0]   lane_cnt;
`endif

    int n_vec;
    int n_err;

    demux_1_4_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX_CNT_EN
        ,
        .lane_cnt  (lane_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check(input string tag, input logic [4*WIDTH-1:0] obs,
                         input logic [4*WIDTH-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] lane(input int i);
        return out_data[i*WIDTH +: WIDTH];
    endfunction

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'hF;

        // Reset state.
        #3;
        check("rst_valid", 192'(out_valid), 192'(4'b0000));
        check("rst_data",  out_data, '0);
        check("rst_ready", 192'(in_ready), 192'(1'b0));
        tick();
        tick();
        rst_n = 1'b1;

        // 1. Back-to-back words to lanes 0..3, all consumers ready.
        in_valid = 1'b1; in_sel = 2'd0; in_data = 48'h1;
        #1 check("t1_rdy0", 192'(in_ready), 192'(1'b1));
        tick();
        check("t1_v0", 192'(out_valid), 192'(4'b0001));
        check("t1_d0", 192'(lane(0)), 192'(48'h1));
        in_sel = 2'd1; in_data = 48'h2;
        #1 check("t1_rdy1", 192'(in_ready), 192'(1'b1));
        tick();
        check("t1_v1", 192'(out_valid), 192'(4'b0010));
        check("t1_d1", 192'(lane(1)), 192'(48'h2));
        in_sel = 2'd2; in_data = 48'h3;
        #1 check("t1_rdy2", 192'(in_ready), 192'(1'b1));
        tick();
        check("t1_v2", 192'(out_valid), 192'(4'b0100));
        check("t1_d2", 192'(lane(2)), 192'(48'h3));
        in_sel = 2'd3; in_data = 48'h4;
        #1 check("t1_rdy3", 192'(in_ready), 192'(1'b1));
        tick();
        check("t1_v3", 192'(out_valid), 192'(4'b1000));
        check("t1_d3", 192'(lane(3)), 192'(48'h4));
        in_valid = 1'b0;
        tick();
        check("t1_empty", 192'(out_valid), 192'(4'b0000));

        // 2. Stall lane 2, then simultaneous drain and accept.
        out_ready = 4'b1011;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 48'hAAAA;
        tick();
        check("t2_v_a", 192'(out_valid), 192'(4'b0100));
        check("t2_d_a", 192'(lane(2)), 192'(48'hAAAA));
        in_data = 48'hBBBB;
        #1 check("t2_rdy_blk", 192'(in_ready), 192'(1'b0));
        tick();
        check("t2_hold_v", 192'(out_valid), 192'(4'b0100));
        check("t2_hold_d", 192'(lane(2)), 192'(48'hAAAA));
        out_ready = 4'hF;
        #1 check("t2_rdy_pass", 192'(in_ready), 192'(1'b1));
        tick();
        check("t2_swap_v", 192'(out_valid), 192'(4'b0100));
        check("t2_swap_d", 192'(lane(2)), 192'(48'hBBBB));
        in_valid = 1'b0;
        tick();
        check("t2_drain_v", 192'(out_valid), 192'(4'b0000));
        check("t2_keep_d", 192'(lane(2)), 192'(48'hBBBB));

        // 3. Lane 1 stalled and full; lane 3 still accepts.
        out_ready = 4'b1101;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 48'h77;
        tick();
        in_sel = 2'd3; in_data = 48'h55;
        #1 check("t3_rdy", 192'(in_ready), 192'(1'b1));
        tick();
        check("t3_v", 192'(out_valid), 192'(4'b1010));
        check("t3_d3", 192'(lane(3)), 192'(48'h55));
        check("t3_d1", 192'(lane(1)), 192'(48'h77));
        in_valid = 1'b0;
        tick();
        check("t3_v_after", 192'(out_valid), 192'(4'b0010));

        // 4. Fill lanes 0 and 3, then flush with a pending input.
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 48'h10;
        tick();
        in_sel = 2'd3; in_data = 48'h30;
        tick();
        check("t4_full", 192'(out_valid), 192'(4'b1011));
        flush = 1'b1; in_sel = 2'd2; in_data = 48'h99;
        #1 check("t4_rdy", 192'(in_ready), 192'(1'b0));
        tick();
        check("t4_v", 192'(out_valid), 192'(4'b0000));
        check("t4_d0", 192'(lane(0)), 192'(48'h10));
        check("t4_d3", 192'(lane(3)), 192'(48'h30));
        check("t4_d2", 192'(lane(2)), 192'(48'hBBBB));
        flush = 1'b0; in_valid = 1'b0;
        tick();

        // 5. Asynchronous reset mid-cycle with lanes full.
        in_valid = 1'b1; in_sel = 2'd0; in_data = 48'hC0;
        tick();
        in_sel = 2'd1; in_data = 48'hC1;
        tick();
        check("t5_full", 192'(out_valid), 192'(4'b0011));
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_v", 192'(out_valid), 192'(4'b0000));
        check("t5_rst_d", out_data, '0);
        check("t5_rst_rdy", 192'(in_ready), 192'(1'b0));
        #1 rst_n = 1'b1;
        in_sel = 2'd2; in_data = 48'hD2;
        #1 check("t5_rel_rdy", 192'(in_ready), 192'(1'b1));
        tick();
        check("t5_rel_v", 192'(out_valid), 192'(4'b0100));
        check("t5_rel_d", 192'(lane(2)), 192'(48'hD2));
        in_valid = 1'b0;

`ifdef DEMUX_CNT_EN
        // 6. 17 handshakes on lane 0 wrap its 4-bit counter to 1.
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        out_ready = 4'hF;
        in_valid = 1'b1; in_sel = 2'd0;
        for (int k = 0; k < 17; k++) begin
            in_data = 48'(k + 1);
            tick();
        end
        check("t6_cnt_wrap0", 192'(lane_cnt), 192'(16'h0000));
        in_valid = 1'b0;
        tick();
        check("t6_cnt", 192'(lane_cnt), 192'(16'h0001));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
